// File: rtl/upsampling_read_fifo_rep.sv
// Read-side buffer for the upsampling datapath: inferred-RAM FIFO that can present
// each stored word several times before popping it, with registered ready flags.
module upsampling_read_fifo_rep #(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 7,
    parameter int REP_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic [REP_BITS-1:0]  rep_factor,
    output logic [ADDR_BITS:0]   data_count,
    input  logic [ADDR_BITS:0]   M_count,
    output logic                 M_Ready,
    input  logic [ADDR_BITS:0]   S_margin,
    output logic                 S_Ready,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [REP_BITS-1:0]  rep_cnt_q, rep_cnt_d;
    logic [REP_BITS-1:0]  rep_lat_q, rep_lat_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 m_ready_q, m_ready_d;
    logic                 s_ready_q, s_ready_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [WIDTH-1:0]     dout_q;

    logic                 full_w, empty_w, wr_acc, rd_acc, pop;
    logic [REP_BITS-1:0]  rep_eff, lat_now;

    always_comb begin
        full_w  = (count_q == DEPTH_C);
        empty_w = (count_q == '0);
        wr_acc  = wr_en & ~full_w;
        rd_acc  = rd_en & ~empty_w;
        rep_eff = (rep_factor == '0) ? REP_BITS'(1) : rep_factor;
        // The first beat of a word uses the live factor; later beats use the latched one.
        lat_now = (rep_cnt_q == '0) ? rep_eff : rep_lat_q;
        pop     = rd_acc && (({1'b0, rep_cnt_q} + (REP_BITS+1)'(1)) == {1'b0, lat_now});

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rep_cnt_d    = rep_cnt_q;
        rep_lat_d    = rep_lat_q;
        count_d      = count_q;
        dout_valid_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end
        if (rd_acc) begin
            rep_cnt_d = rep_cnt_q + REP_BITS'(1);
            if (rep_cnt_q == '0) begin
                rep_lat_d = rep_eff;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + ADDR_BITS'(1);
                rep_cnt_d = '0;
            end
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
            2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
            default: count_d = count_q;
        endcase

        // Extra bit keeps count + margin from wrapping when the margin exceeds the depth.
        m_ready_d   = (count_q >= M_count);
        s_ready_d   = (({1'b0, count_q} + {1'b0, S_margin}) < {1'b0, DEPTH_C});
        overflow_d  = overflow_q  | (wr_en & full_w);
        underflow_d = underflow_q | (rd_en & empty_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rep_cnt_q    <= '0;
            rep_lat_q    <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            m_ready_q    <= 1'b0;
            s_ready_q    <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_lat_q    <= rep_lat_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            m_ready_q    <= m_ready_d;
            s_ready_q    <= s_ready_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Registered RAM read; holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign data_count = count_q;
    assign M_Ready    = m_ready_q;
    assign S_Ready    = s_ready_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
endmodule

// File: tb/tb_upsampling_read_fifo_rep.sv
// Scenario bench for upsampling_read_fifo_rep: fill/drain, replication, thresholds,
// full/empty boundaries and mid-operation reset, with a queue-based read scoreboard.
module tb_upsampling_read_fifo_rep;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic         wr_en, rd_en;
    logic [127:0] dout;
    logic         dout_valid;
    logic [2:0]   rep_factor;
    logic [7:0]   data_count, M_count, S_margin;
    logic         M_Ready, S_Ready, full, empty, overflow, underflow;

    int checks = 0;
    int failures = 0;
    logic [127:0] mq[$];
    logic [127:0] exp_q[$];
    logic [127:0] exp_w;

    always #5 clk = ~clk;

    upsampling_read_fifo_rep dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .rep_factor(rep_factor),
        .data_count(data_count), .M_count(M_count), .M_Ready(M_Ready),
        .S_margin(S_margin), .S_Ready(S_Ready), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic step(input logic w, input logic [127:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; M_count = 8'd0; S_margin = 8'd4; rep_factor = 3'd1;
        step(0, '0, 0);
        step(0, '0, 0);
        checks++; if (data_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", data_count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
        checks++; if (M_Ready !== 1'b0 || S_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=01", M_Ready, S_Ready); end
        checks++; if (dout !== '0 || dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout got=%0h/%b exp=0/0", dout, dout_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", overflow, underflow); end
        rst = 1'b0;
        step(0, '0, 0);
        checks++; if (M_Ready !== 1'b1) begin failures++; $display("FAIL mcount_zero got=%b exp=1", M_Ready); end
        M_count = 8'd16;
        step(0, '0, 0);
        checks++; if (M_Ready !== 1'b0) begin failures++; $display("FAIL mcount16_empty got=%b exp=0", M_Ready); end
    endtask

    task automatic test_fill_drain();
        rep_factor = 3'd1;
        for (int i = 0; i < 128; i++) begin
            step(1, 128'(i), 0);
            mq.push_back(128'(i));
        end
        checks++; if (full !== 1'b1 || data_count !== 8'd128) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/128", full, data_count); end
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back(mq.pop_front());
            step(0, '0, 1);
            exp_w = exp_q.pop_front();
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                failures++; $display("FAIL drain_beat%0d got=%0h/%b exp=%0h/1", i, dout, dout_valid, exp_w);
            end else $display("drain beat %0d dout=%0h", i, dout);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL drain_errs got=%b%b exp=00", overflow, underflow); end
        step(0, '0, 0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", dout_valid); end
    endtask

    task automatic test_replication();
        logic [7:0] exp_cnt;
        rep_factor = 3'd3;
        step(1, 128'hAAAA, 0);
        step(1, 128'hBBBB, 0);
        for (int b = 0; b < 6; b++) begin
            exp_q.push_back(b < 3 ? 128'hAAAA : 128'hBBBB);
            exp_cnt = (b < 2) ? 8'd2 : ((b < 5) ? 8'd1 : 8'd0);
            step(0, '0, 1);
            exp_w = exp_q.pop_front();
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                failures++; $display("FAIL rep_beat%0d got=%0h/%b exp=%0h/1", b, dout, dout_valid, exp_w);
            end else $display("rep beat %0d dout=%0h count=%0d", b, dout, data_count);
            checks++;
            if (data_count !== exp_cnt) begin
                failures++; $display("FAIL rep_count%0d got=%0d exp=%0d", b, data_count, exp_cnt);
            end
        end
        rep_factor = 3'd1;
    endtask

    task automatic test_thresholds();
        M_count = 8'd16; S_margin = 8'd4;
        for (int i = 0; i < 16; i++) begin
            step(1, 128'(1000 + i), 0);
            mq.push_back(128'(1000 + i));
        end
        checks++; if (data_count !== 8'd16 || M_Ready !== 1'b0) begin failures++; $display("FAIL mready_early got=%0d/%b exp=16/0", data_count, M_Ready); end
        step(0, '0, 0);
        checks++; if (M_Ready !== 1'b1) begin failures++; $display("FAIL mready_rise got=%b exp=1", M_Ready); end
        for (int i = 16; i < 124; i++) begin
            step(1, 128'(1000 + i), 0);
            mq.push_back(128'(1000 + i));
        end
        checks++; if (data_count !== 8'd124 || S_Ready !== 1'b1) begin failures++; $display("FAIL sready_early got=%0d/%b exp=124/1", data_count, S_Ready); end
        step(0, '0, 0);
        checks++; if (S_Ready !== 1'b0) begin failures++; $display("FAIL sready_fall got=%b exp=0", S_Ready); end
    endtask

    task automatic test_boundaries();
        logic [127:0] last_w;
        for (int i = 124; i < 128; i++) begin
            step(1, 128'(1000 + i), 0);
            mq.push_back(128'(1000 + i));
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL bnd_full got=%b exp=1", full); end
        exp_q.push_back(mq.pop_front());
        step(1, 128'hDEAD, 1);
        exp_w = exp_q.pop_front();
        checks++; if (overflow !== 1'b1 || data_count !== 8'd127) begin failures++; $display("FAIL bnd_overflow got=%b/%0d exp=1/127", overflow, data_count); end
        checks++; if (dout_valid !== 1'b1 || dout !== exp_w) begin failures++; $display("FAIL bnd_pop got=%0h/%b exp=%0h/1", dout, dout_valid, exp_w); end
        last_w = exp_w;
        while (mq.size() > 0) begin
            exp_q.push_back(mq.pop_front());
            step(0, '0, 1);
            exp_w = exp_q.pop_front();
            last_w = exp_w;
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                failures++; $display("FAIL bnd_drain got=%0h/%b exp=%0h/1", dout, dout_valid, exp_w);
            end else $display("bnd drain dout=%0h", dout);
        end
        checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin failures++; $display("FAIL bnd_empty got=%b/%b exp=1/0", empty, underflow); end
        step(0, '0, 1);
        checks++; if (underflow !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL bnd_underflow got=%b/%b exp=1/0", underflow, dout_valid); end
        checks++; if (dout !== last_w || data_count !== 8'd0) begin failures++; $display("FAIL bnd_hold got=%0h/%0d exp=%0h/0", dout, data_count, last_w); end
    endtask

    task automatic test_reset_mid();
        rep_factor = 3'd3;
        for (int i = 0; i < 50; i++) step(1, 128'(2000 + i), 0);
        step(0, '0, 1);
        checks++; if (data_count !== 8'd50 || dout !== 128'(2000)) begin failures++; $display("FAIL mid_pre got=%0d/%0h exp=50/7d0", data_count, dout); end
        rst = 1'b1;
        step(0, '0, 0);
        rst = 1'b0;
        checks++; if (data_count !== 8'd0 || empty !== 1'b1) begin failures++; $display("FAIL mid_count got=%0d/%b exp=0/1", data_count, empty); end
        checks++; if (M_Ready !== 1'b0 || S_Ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b%b exp=01", M_Ready, S_Ready); end
        checks++; if (dout !== '0 || dout_valid !== 1'b0) begin failures++; $display("FAIL mid_dout got=%0h/%b exp=0/0", dout, dout_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL mid_errs got=%b%b exp=00", overflow, underflow); end
        rep_factor = 3'd1;
        step(1, 128'hBEEF, 0);
        exp_q.push_back(128'hBEEF);
        step(0, '0, 1);
        exp_w = exp_q.pop_front();
        checks++; if (dout_valid !== 1'b1 || dout !== exp_w) begin failures++; $display("FAIL mid_newword got=%0h/%b exp=%0h/1", dout, dout_valid, exp_w); end
        checks++; if (data_count !== 8'd0) begin failures++; $display("FAIL mid_pop got=%0d exp=0", data_count); end
    endtask

    initial begin
        rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        rep_factor = 3'd1; M_count = 8'd16; S_margin = 8'd4;
        #1;
        test_reset();
        test_fill_drain();
        test_replication();
        test_thresholds();
        test_boundaries();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
